// File: rtl/elevator_pkg.sv
// Shared constants for the elevator call panel and its scheduler.
//   ST_*      : controller state_out encodings
//   FLOOR_W   : floor number width, matches the controller's r_f/t_f
//   dir_e     : SCAN direction
//   panel_state_e : call panel FSM states
package elevator_pkg;

  localparam int unsigned FLOOR_W = 5;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_MOVING = 3'b001;
  localparam logic [2:0] ST_STOP   = 3'b010;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    P_SCAN     = 2'd0,
    P_ACCEPT   = 2'd1,
    P_TRAVEL   = 2'd2,
    P_WAITIDLE = 2'd3
  } panel_state_e;

endpackage

// File: rtl/floor_scheduler.sv
// SCAN floor picker (combinational).
//   pending    in  : outstanding calls, bit i = floor i
//   last_floor in  : floor the car was last sent to / stopped at
//   dir        in  : current travel direction
//   sel        out : chosen floor, zero-extended to FLOOR_W
//   sel_valid  out : at least one call is pending
//   sel_dir    out : direction whose rule produced sel
module floor_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 8
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    last_floor,
  input  logic                  dir,
  output logic [FLOOR_W-1:0]    sel,
  output logic                  sel_valid,
  output logic                  sel_dir
);

  logic               w_up_found;
  logic               w_dn_found;
  logic [FLOOR_W-1:0] w_up_sel;
  logic [FLOOR_W-1:0] w_dn_sel;

  // Lowest pending floor at or above last_floor (scan downward, last hit wins).
  always_comb begin
    w_up_found = 1'b0;
    w_up_sel   = '0;
    for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) >= last_floor)) begin
        w_up_found = 1'b1;
        w_up_sel   = FLOOR_W'(i);
      end
    end
  end

  // Highest pending floor at or below last_floor (scan upward, last hit wins).
  always_comb begin
    w_dn_found = 1'b0;
    w_dn_sel   = '0;
    for (int i = 0; i < int'(NUM_FLOORS); i++) begin
      if (pending[i] && (FLOOR_W'(i) <= last_floor)) begin
        w_dn_found = 1'b1;
        w_dn_sel   = FLOOR_W'(i);
      end
    end
  end

  // Keep direction when possible, otherwise reverse.
  always_comb begin
    sel       = '0;
    sel_dir   = dir;
    sel_valid = w_up_found | w_dn_found;
    if (dir == DIR_UP) begin
      if (w_up_found) begin
        sel     = w_up_sel;
        sel_dir = DIR_UP;
      end else if (w_dn_found) begin
        sel     = w_dn_sel;
        sel_dir = DIR_DOWN;
      end
    end else begin
      if (w_dn_found) begin
        sel     = w_dn_sel;
        sel_dir = DIR_DOWN;
      end else if (w_up_found) begin
        sel     = w_up_sel;
        sel_dir = DIR_UP;
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Request side of the elevator controller: latches button presses, picks the
// next floor with SCAN, issues it on r_f one request at a time and retires it
// once the controller reports the stop.
//   clk, reset   : clock, async active-high reset
//   btn          : raw call buttons (level), bit i = floor i
//   state_out    : controller state (idle / moving / stop)
//   r_f          : request floor to the controller (a change = new request)
//   pending      : outstanding calls
//   busy         : request in flight (FSM not scanning)
//   served       : one-cycle pulse when a call is retired
//   served_floor : floor of the last retired call (held)
//   err          : sticky, controller did not accept in time
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS     = 8,
  parameter int unsigned ACCEPT_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [2:0]            state_out,
  output logic [FLOOR_W-1:0]    r_f,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  served,
  output logic [FLOOR_W-1:0]    served_floor,
  output logic                  err
);

  localparam int unsigned TMO_W = (ACCEPT_TIMEOUT > 2) ? $clog2(ACCEPT_TIMEOUT) : 1;

  panel_state_e              r_state;
  logic [NUM_FLOORS-1:0]     r_btn_q;
  logic [FLOOR_W-1:0]        r_last_floor;
  logic                      r_dir;
  logic [TMO_W-1:0]          r_tmo_cnt;

  logic [NUM_FLOORS-1:0]     w_rise;
  logic [NUM_FLOORS-1:0]     w_clr;
  logic [FLOOR_W-1:0]        w_sel;
  logic                      w_sel_valid;
  logic                      w_sel_dir;
  logic                      w_retire_scan;
  logic                      w_retire_travel;
  logic [FLOOR_W-1:0]        w_retire_floor;

  floor_scheduler #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_sched (
    .pending    (pending),
    .last_floor (r_last_floor),
    .dir        (r_dir),
    .sel        (w_sel),
    .sel_valid  (w_sel_valid),
    .sel_dir    (w_sel_dir)
  );

  assign w_rise = btn & ~r_btn_q;

  // Retire conditions: car already at the selected floor, or the controller stopped.
  assign w_retire_scan   = (r_state == P_SCAN) && (state_out == ST_IDLE) &&
                           w_sel_valid && (w_sel == r_last_floor);
  assign w_retire_travel = (r_state == P_TRAVEL) && (state_out == ST_STOP);
  assign w_retire_floor  = w_retire_travel ? r_f : w_sel;
  assign w_clr           = (w_retire_scan || w_retire_travel) ?
                           (NUM_FLOORS'(1) << w_retire_floor) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= P_SCAN;
      r_btn_q      <= '0;
      r_last_floor <= '0;
      r_dir        <= DIR_UP;
      r_tmo_cnt    <= '0;
      r_f          <= '0;
      pending      <= '0;
      busy         <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
      err          <= 1'b0;
    end else begin
      r_btn_q <= btn;
      // A press landing on the bit being retired is dropped.
      pending <= (pending | w_rise) & ~w_clr;
      served  <= 1'b0;

      case (r_state)
        P_SCAN: begin
          if (state_out == ST_IDLE && w_sel_valid) begin
            if (w_retire_scan) begin
              served       <= 1'b1;
              served_floor <= w_sel;
            end else begin
              // sel != last_floor here, so sel_dir is exactly the move direction.
              r_f       <= w_sel;
              r_dir     <= w_sel_dir;
              r_tmo_cnt <= '0;
              r_state   <= P_ACCEPT;
              busy      <= 1'b1;
            end
          end
        end

        P_ACCEPT: begin
          if (state_out == ST_MOVING) begin
            r_state <= P_TRAVEL;
          end else if (r_tmo_cnt == TMO_W'(ACCEPT_TIMEOUT - 1)) begin
            err          <= 1'b1;
            r_last_floor <= r_f;
            r_state      <= P_SCAN;
            busy         <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end
        end

        P_TRAVEL: begin
          // ST_STOP is a single cycle, so it is sampled every cycle.
          if (w_retire_travel) begin
            served       <= 1'b1;
            served_floor <= r_f;
            r_last_floor <= r_f;
            r_state      <= P_WAITIDLE;
          end
        end

        P_WAITIDLE: begin
          // Next r_f change must land in controller idle, never in its queue.
          if (state_out == ST_IDLE) begin
            r_state <= P_SCAN;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= P_SCAN;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Bench for elevator_call_panel: behavioural controller model, SCAN order
// reference computed from the pressed set, directed corner cases.
module tb_elevator_call_panel;
  import elevator_pkg::*;

  localparam int unsigned NF = 8;

  logic                 clk;
  logic                 reset;
  logic [NF-1:0]        btn;
  logic [2:0]           state_out;
  logic [FLOOR_W-1:0]   r_f;
  logic [NF-1:0]        pending;
  logic                 busy;
  logic                 served;
  logic [FLOOR_W-1:0]   served_floor;
  logic                 err;

  elevator_call_panel #(
    .NUM_FLOORS     (NF),
    .ACCEPT_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .state_out    (state_out),
    .r_f          (r_f),
    .pending      (pending),
    .busy         (busy),
    .served       (served),
    .served_floor (served_floor),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- controller model ----------------
  logic               stub_mode;
  logic [2:0]         c_st;
  logic [FLOOR_W-1:0] c_floor;
  logic [FLOOR_W-1:0] c_last_rf;
  int                 c_cnt;

  assign state_out = c_st;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c_st      <= ST_IDLE;
      c_floor   <= '0;
      c_last_rf <= '0;
      c_cnt     <= 0;
    end else begin
      case (c_st)
        ST_IDLE: begin
          if (!stub_mode && r_f != c_last_rf) begin
            c_last_rf <= r_f;
            if (r_f != c_floor) begin
              c_st  <= ST_MOVING;
              c_cnt <= (r_f > c_floor) ? int'(r_f - c_floor) : int'(c_floor - r_f);
            end
          end
        end
        ST_MOVING: begin
          if (c_cnt <= 1) begin
            c_st    <= ST_STOP;
            c_floor <= c_last_rf;
          end else begin
            c_cnt <= c_cnt - 1;
          end
        end
        default: c_st <= ST_IDLE;
      endcase
    end
  end

  // ---------------- served monitor ----------------
  int svq[$];
  always @(negedge clk) begin
    if (!reset && served) svq.push_back(int'(served_floor));
  end

  // ---------------- checking ----------------
  int n_assert;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- reference model ----------------
  int m_pos;
  bit m_up;

  // SCAN order for a set pressed together: rest of the current sweep, then
  // the far side in the reverse sweep.
  task automatic run_batch(input logic [NF-1:0] mask, input string tag);
    int exp_q[$];
    int cur;
    int cyc;
    exp_q.delete();
    if (m_up) begin
      for (int f = m_pos; f < int'(NF); f++) if (mask[f]) exp_q.push_back(f);
      for (int f = m_pos - 1; f >= 0; f--)   if (mask[f]) exp_q.push_back(f);
    end else begin
      for (int f = m_pos; f >= 0; f--)       if (mask[f]) exp_q.push_back(f);
      for (int f = m_pos + 1; f < int'(NF); f++) if (mask[f]) exp_q.push_back(f);
    end
    cur = m_pos;
    foreach (exp_q[k]) begin
      if (exp_q[k] > cur) m_up = 1'b1;
      if (exp_q[k] < cur) m_up = 1'b0;
      cur = exp_q[k];
    end
    m_pos = cur;

    svq.delete();
    btn = mask;
    tick(1);
    btn = '0;
    chk({tag, "_pending_set"}, 32'(pending), 32'(mask));
    cyc = 0;
    while (cyc < 600 && svq.size() < exp_q.size()) begin
      tick(1);
      cyc++;
    end
    tick(10);
    chk({tag, "_served_count"}, 32'(svq.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) begin
      chk($sformatf("%s_order%0d", tag, k), (k < svq.size()) ? 32'(svq[k]) : 32'hFFFF_FFFF,
          32'(exp_q[k]));
    end
    chk({tag, "_pending_empty"}, 32'(pending), 32'h0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit saw_mov;
    bit saw_stop;
    bit bad;
    bit found;
    int cyc;

    n_assert  = 0;
    n_fail    = 0;
    btn       = '0;
    stub_mode = 1'b0;
    reset     = 1'b1;
    m_pos     = 0;
    m_up      = 1'b1;
    tick(3);
    chk("rst_rf", 32'(r_f), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_served", 32'(served), 0);
    chk("rst_served_floor", 32'(served_floor), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;
    tick(2);

    // Call at the floor the car is already on.
    svq.delete();
    btn = NF'(1);
    tick(1);
    btn = '0;
    chk("t2_pending", 32'(pending), 32'h1);
    tick(1);
    chk("t2_served", 32'(served), 1);
    chk("t2_served_floor", 32'(served_floor), 0);
    chk("t2_pending_clr", 32'(pending), 0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || state_out !== ST_IDLE || r_f !== '0) bad = 1'b1;
      tick(1);
    end
    chk("t2_quiet", 32'(bad), 0);
    chk("t2_one_pulse", 32'(svq.size()), 1);

    // Single call to floor 3.
    svq.delete();
    btn = NF'(8);
    tick(1);
    btn = '0;
    chk("t1_pending", 32'(pending), 32'h08);
    chk("t1_rf_before", 32'(r_f), 0);
    tick(1);
    chk("t1_rf", 32'(r_f), 3);
    chk("t1_busy", 32'(busy), 1);
    saw_mov  = 1'b0;
    saw_stop = 1'b0;
    cyc = 0;
    while (cyc < 100 && svq.size() == 0) begin
      tick(1);
      if (state_out == ST_MOVING) saw_mov = 1'b1;
      if (state_out == ST_STOP && saw_mov) saw_stop = 1'b1;
      cyc++;
    end
    chk("t1_saw_moving", 32'(saw_mov), 1);
    chk("t1_saw_stop", 32'(saw_stop), 1);
    chk("t1_served", 32'(served), 1);
    chk("t1_served_floor", 32'(served_floor), 3);
    chk("t1_pending_clr", 32'(pending), 0);
    tick(1);
    chk("t1_served_pulse", 32'(served), 0);
    tick(5);
    m_pos = 3;
    m_up  = 1'b1;

    // Car at 3 going up, calls 5, 2, 7 together.
    run_batch(8'b1010_0100, "t3");
    chk("t3_first", (svq.size() > 0) ? 32'(svq[0]) : 32'hFFFF_FFFF, 5);
    chk("t3_second", (svq.size() > 1) ? 32'(svq[1]) : 32'hFFFF_FFFF, 7);
    chk("t3_third", (svq.size() > 2) ? 32'(svq[2]) : 32'hFFFF_FFFF, 2);

    // Random batches against the SCAN order model.
    for (int b = 0; b < 15; b++) begin
      run_batch(NF'($urandom_range(1, 255)), $sformatf("rnd%0d", b));
    end

    // Re-press of the target floor in the stop cycle.
    if (m_pos == 6) run_batch(NF'(1), "t5_pre");
    svq.delete();
    btn = NF'(8'h40);
    tick(1);
    btn = '0;
    found = 1'b0;
    cyc = 0;
    while (cyc < 100 && !found) begin
      tick(1);
      if (state_out == ST_STOP) found = 1'b1;
      cyc++;
    end
    chk("t5_stop_seen", 32'(found), 1);
    btn = NF'(8'h40);
    tick(1);
    chk("t5_served", 32'(served), 1);
    chk("t5_served_floor", 32'(served_floor), 6);
    chk("t5_clear_wins", 32'(pending), 0);
    btn = '0;
    tick(12);
    chk("t5_one_pulse", 32'(svq.size()), 1);
    chk("t5_pending_final", 32'(pending), 0);
    m_up  = (6 > m_pos);
    m_pos = 6;

    // Reset in the middle of a travel with calls 5 and 7 outstanding.
    btn = NF'(8'hA0);
    tick(1);
    btn = '0;
    found = 1'b0;
    cyc = 0;
    while (cyc < 50 && !found) begin
      tick(1);
      if (state_out == ST_MOVING) found = 1'b1;
      cyc++;
    end
    chk("t6_moving_seen", 32'(found), 1);
    tick(1);
    chk("t6_busy_before", 32'(busy), 1);
    chk("t6_pending_before", 32'(pending), 32'hA0);
    svq.delete();
    reset = 1'b1;
    #1;
    chk("t6_rst_rf", 32'(r_f), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_served", 32'(served), 0);
    chk("t6_rst_served_floor", 32'(served_floor), 0);
    chk("t6_rst_err", 32'(err), 0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t6_no_serve", 32'(svq.size()), 0);
    chk("t6_still_idle", 32'(busy), 0);
    m_pos = 0;
    m_up  = 1'b1;

    // Controller that never accepts.
    stub_mode = 1'b1;
    btn = NF'(8'h10);
    tick(1);
    btn = '0;
    tick(1);
    chk("t4_rf", 32'(r_f), 4);
    tick(3);
    chk("t4_err_early", 32'(err), 0);
    chk("t4_busy_wait", 32'(busy), 1);
    tick(1);
    chk("t4_err", 32'(err), 1);
    chk("t4_back_to_scan", 32'(busy), 0);
    chk("t4_pending_kept", 32'(pending[4]), 1);
    tick(6);
    chk("t4_err_sticky", 32'(err), 1);
    reset = 1'b1;
    #1;
    chk("t4_err_reset", 32'(err), 0);
    tick(2);
    reset     = 1'b0;
    stub_mode = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
